fifo_rd_packer: RTL and testbench

// - Read-side drain engine for the async FIFO; sits in the Rd_Clk domain on the FIFO read port.
// - Pops Bsize-bit words via active-low nRd/Empty/Dout and packs PACK of them into one wide output word.
// - Presents packed words on a valid/ready stream. Flush (or optional idle timeout) emits a partial word.

---
 rtl/fifo_rd_packer_if.sv | 31 +++
 rtl/fifo_rd_packer.sv | 154 +++++++++++++++
 tb/tb_fifo_rd_packer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - FIFO read port and packed-word stream bundle for fifo_rd_packer
interface fifo_rd_packer_if #(
  parameter int Bsize = 8,
  parameter int PACK  = 4
);
  localparam int CW = $clog2(PACK + 1);

  // FIFO read side (active-low strobe, head word on Dout)
  logic                  Empty;
  logic [Bsize-1:0]      Dout;
  logic                  nRd;
  logic                  Flush;

  // Packed output stream
  logic [Bsize*PACK-1:0] Pk_Data;
  logic                  Pk_Valid;
  logic                  Pk_Ready;
  logic [CW-1:0]         Pk_Cnt;

  // Packer side: consumes the FIFO, produces the stream
  modport master (
    input  Empty, Dout, Flush, Pk_Ready,
    output nRd, Pk_Data, Pk_Valid, Pk_Cnt
  );

  // Environment side: FIFO model and stream sink
  modport slave (
    output Empty, Dout, Flush, Pk_Ready,
    input  nRd, Pk_Data, Pk_Valid, Pk_Cnt
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - async FIFO read-side drain packing PACK words per output beat (optional FLUSH_TIMEOUT_EN)
module fifo_rd_packer #(
  parameter int Bsize   = 8,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              Rd_Clk,
  input  logic              nRst,
  fifo_rd_packer_if.master  bus
);

  localparam int            CW       = $clog2(PACK + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(PACK);

  // Elaboration-time range checks on the configuration
  if (PACK < 2 || PACK > 16) begin : g_bad_pack
    $error("fifo_rd_packer: PACK must be within 2..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_rd_packer: TIMEOUT must be >= 1");
  end

  // Accumulator: lane i holds the i-th word popped since the last load
  logic [PACK-1:0][Bsize-1:0] acc_q, acc_d;
  logic [CW-1:0]              acc_cnt_q, acc_cnt_d;

  // Output register presented on the stream
  logic [Bsize*PACK-1:0]      pk_data_q, pk_data_d;
  logic [CW-1:0]              pk_cnt_q, pk_cnt_d;
  logic                       pk_valid_q, pk_valid_d;

  // Partial-word emission request; blocks further pops until served
  logic                       flush_pend_q, flush_pend_d;

  logic                       out_free;
  logic                       acc_full;
  logic                       acc_some;
  logic                       load;
  logic                       pop;
  logic                       timeout_hit;

  // Handshake decode: load the output register when it is free and there is a
  // full word (or a pending flush with something held); pop whenever a slot exists
  // after this edge, including the slot freed by a same-edge load.
  always_comb begin
    out_free = ~pk_valid_q | bus.Pk_Ready;
    acc_full = (acc_cnt_q == FULL_CNT);
    acc_some = (acc_cnt_q != '0);
    load     = out_free & (acc_full | (flush_pend_q & acc_some));
    pop      = nRst & ~bus.Empty & ~flush_pend_q & (~acc_full | load);
  end

  assign bus.nRd      = ~pop;
  assign bus.Pk_Data  = pk_data_q;
  assign bus.Pk_Cnt   = pk_cnt_q;
  assign bus.Pk_Valid = pk_valid_q;

  // Accumulator next state: a load empties it, a same-edge pop restarts it at lane 0
  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    if (load) begin
      acc_d     = '0;
      acc_cnt_d = '0;
      if (pop) begin
        acc_d[0]  = bus.Dout;
        acc_cnt_d = CW'(1);
      end
    end else if (pop) begin
      for (int i = 0; i < PACK; i++) begin
        if (acc_cnt_q == CW'(i)) begin
          acc_d[i] = bus.Dout;
        end
      end
      acc_cnt_d = acc_cnt_q + CW'(1);
    end
  end

  // Output register next state: data/count only change on load, so they hold under backpressure
  always_comb begin
    pk_data_d  = pk_data_q;
    pk_cnt_d   = pk_cnt_q;
    pk_valid_d = pk_valid_q;
    if (load) begin
      pk_data_d  = acc_q;
      pk_cnt_d   = acc_cnt_q;
      pk_valid_d = 1'b1;
    end else if (pk_valid_q & bus.Pk_Ready) begin
      pk_valid_d = 1'b0;
    end
  end

  // Flush request: a pending request is retired by the load it causes, or
  // immediately when there is nothing to emit; new requests are absorbed meanwhile.
  always_comb begin
    if (flush_pend_q) begin
      flush_pend_d = ~(load | ~acc_some);
    end else begin
      flush_pend_d = bus.Flush | timeout_hit;
    end
  end

`ifdef FLUSH_TIMEOUT_EN
  localparam int            IW       = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  logic [IW-1:0] idle_q, idle_d;

  // Idle timer: counts stalled cycles with a partial word held, fires a flush at TIMEOUT
  always_comb begin
    idle_d      = idle_q;
    timeout_hit = 1'b0;
    if (pop | load) begin
      idle_d = '0;
    end else if (idle_q == IDLE_MAX) begin
      idle_d      = '0;
      timeout_hit = 1'b1;
    end else if (acc_some & ~flush_pend_q) begin
      idle_d = idle_q + IW'(1);
    end
  end

  // Idle timer register
  always_ff @(posedge Rd_Clk or negedge nRst) begin
    if (!nRst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State registers; reset drops any held words and the presented beat
  always_ff @(posedge Rd_Clk or negedge nRst) begin
    if (!nRst) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      pk_data_q    <= '0;
      pk_cnt_q     <= '0;
      pk_valid_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      pk_data_q    <= pk_data_d;
      pk_cnt_q     <= pk_cnt_d;
      pk_valid_q   <= pk_valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - self-checking bench for fifo_rd_packer with queue-based reference model
module tb_fifo_rd_packer;

  localparam int BS = 8;
  localparam int PK = 4;
  localparam int TO = 16;

  logic Rd_Clk = 1'b0;
  logic nRst   = 1'b0;

  fifo_rd_packer_if #(.Bsize(BS), .PACK(PK)) bus ();

  fifo_rd_packer #(.Bsize(BS), .PACK(PK), .TIMEOUT(TO)) dut (
    .Rd_Clk (Rd_Clk),
    .nRst   (nRst),
    .bus    (bus)
  );

  always #5 Rd_Clk = ~Rd_Clk;

  // Environment FIFO contents and reference model state
  logic [7:0]  fifo[$];
  logic [7:0]  m_acc[$];
  bit          m_valid;
  logic [31:0] m_data;
  int          m_cnt;
  bit          m_fp;
  int          m_idle;

  // Beats accepted by the sink, words popped, random-phase scoreboard
  logic [31:0] log_d[$];
  int          log_c[$];
  int          pops;
  logic [7:0]  sent[$];
  logic [7:0]  recv[$];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_acc();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < m_acc.size(); i++) v[i*8 +: 8] = m_acc[i];
    return v;
  endfunction

  task automatic model_clear();
    m_acc.delete();
    m_valid = 0;
    m_data  = '0;
    m_cnt   = 0;
    m_fp    = 0;
    m_idle  = 0;
  endtask

  // One clock cycle: drive at negedge, check against the model, advance the model
  task automatic step(input bit hold_empty, input bit ready, input bit flush);
    bit         empty, pop, load, out_free, full, nfp;
    logic [7:0] head;
    @(negedge Rd_Clk);
    nRst  = 1'b1;
    empty = hold_empty || (fifo.size() == 0);
    head  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    bus.Empty    = empty;
    bus.Dout     = head;
    bus.Pk_Ready = ready;
    bus.Flush    = flush;
    #1;
    out_free = !m_valid || ready;
    full     = (m_acc.size() == PK);
    load     = out_free && (full || (m_fp && m_acc.size() != 0));
    pop      = !empty && !m_fp && (!full || load);
    check("nRd", bus.nRd, !pop);
    check("Pk_Valid", bus.Pk_Valid, m_valid);
    if (m_valid) begin
      check("Pk_Data", bus.Pk_Data, m_data);
      check("Pk_Cnt", bus.Pk_Cnt, m_cnt);
      if (ready) begin
        log_d.push_back(bus.Pk_Data);
        log_c.push_back(int'(bus.Pk_Cnt));
      end
    end
    if (m_fp) nfp = !(load || m_acc.size() == 0);
    else      nfp = flush;
`ifdef FLUSH_TIMEOUT_EN
    if (pop || load) m_idle = 0;
    else if (m_idle == TO) begin
      m_idle = 0;
      if (!m_fp) nfp = 1;
    end else if (m_acc.size() != 0 && !m_fp) m_idle++;
`endif
    if (m_valid && ready && !load) m_valid = 0;
    if (load) begin
      m_data  = pack_acc();
      m_cnt   = m_acc.size();
      m_valid = 1;
      m_acc.delete();
    end
    if (pop) begin
      m_acc.push_back(head);
      void'(fifo.pop_front());
      pops++;
    end
    m_fp = nfp;
  endtask

  // Assert reset away from the clock edge and check the asynchronous clear
  task automatic apply_reset();
    @(negedge Rd_Clk);
    nRst         = 1'b0;
    bus.Flush    = 1'b0;
    bus.Pk_Ready = 1'b0;
    bus.Empty    = (fifo.size() == 0);
    bus.Dout     = (fifo.size() != 0) ? fifo[0] : 8'h00;
    #1;
    check("rst_nRd", bus.nRd, 1'b1);
    check("rst_Pk_Valid", bus.Pk_Valid, 1'b0);
    check("rst_Pk_Data", bus.Pk_Data, 32'h0);
    check("rst_Pk_Cnt", bus.Pk_Cnt, 3'd0);
    model_clear();
  endtask

  initial begin
    bus.Empty    = 1'b1;
    bus.Dout     = '0;
    bus.Flush    = 1'b0;
    bus.Pk_Ready = 1'b0;
    model_clear();

    // Reset with a non-empty FIFO, then a back-to-back stream of two words
    for (int i = 1; i <= 8; i++) fifo.push_back(8'(i));
    apply_reset();
    pops = 0;
    log_d.delete(); log_c.delete();
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    check("stream_consecutive_pops", pops, 8);
    for (int k = 0; k < 10 && log_d.size() < 2; k++) step(1, 1, 0);
    check("stream_nwords", log_d.size(), 2);
    if (log_d.size() >= 2) begin
      check("stream_w0", log_d[0], 32'h04030201);
      check("stream_w1", log_d[1], 32'h08070605);
      check("stream_cnt", log_c[0], 4);
    end

    // Backpressure: exactly two words buffered, then drained in order
    for (int i = 1; i <= 12; i++) fifo.push_back(8'(i));
    pops = 0;
    log_d.delete(); log_c.delete();
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    check("bp_pops", pops, 8);
    check("bp_nRd_high", bus.nRd, 1'b1);
    check("bp_hold", bus.Pk_Data, 32'h04030201);
    for (int k = 0; k < 30 && log_d.size() < 3; k++) step(0, 1, 0);
    check("bp_nwords", log_d.size(), 3);
    if (log_d.size() >= 3) begin
      check("bp_w0", log_d[0], 32'h04030201);
      check("bp_w1", log_d[1], 32'h08070605);
      check("bp_w2", log_d[2], 32'h0C0B0A09);
    end

    // Flush of a 3-word partial, flush with nothing held, single-word flush
    fifo.delete();
    fifo.push_back(8'hAA); fifo.push_back(8'hBB);
    fifo.push_back(8'hCC); fifo.push_back(8'hDD);
    log_d.delete(); log_c.delete();
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    check("flush_inhibit", bus.nRd, 1'b1);
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    check("flush_nwords", log_d.size(), 1);
    if (log_d.size() >= 1) begin
      check("flush_w", log_d[0], 32'h00CCBBAA);
      check("flush_cnt", log_c[0], 3);
    end
    step(1, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 0);
    check("flush_empty_noword", log_d.size(), 1);
    check("flush_empty_novalid", bus.Pk_Valid, 1'b0);
    step(0, 1, 0);
    step(1, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    check("flush1_nwords", log_d.size(), 2);
    if (log_d.size() >= 2) begin
      check("flush1_w", log_d[1], 32'h000000DD);
      check("flush1_cnt", log_c[1], 1);
    end

    // Empty toggling every cycle
    for (int i = 1; i <= 8; i++) fifo.push_back(8'(8'h20 + i));
    pops = 0;
    log_d.delete(); log_c.delete();
    for (int i = 0; i < 24; i++) step(i % 2 == 1, 1, 0);
    check("toggle_pops", pops, 8);
    check("toggle_nwords", log_d.size(), 2);
    if (log_d.size() >= 2) begin
      check("toggle_w0", log_d[0], 32'h24232221);
      check("toggle_w1", log_d[1], 32'h28272625);
    end

    // Idle timeout (auto-flush only when the feature is built in)
    fifo.push_back(8'h11); fifo.push_back(8'h22);
    log_d.delete(); log_c.delete();
    step(0, 1, 0);
    step(0, 1, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 0);
`ifdef FLUSH_TIMEOUT_EN
    check("timeout_nwords", log_d.size(), 1);
    if (log_d.size() >= 1) begin
      check("timeout_w", log_d[0], 32'h00002211);
      check("timeout_cnt", log_c[0], 2);
    end
`else
    check("no_timeout_nwords", log_d.size(), 0);
    check("no_timeout_valid", bus.Pk_Valid, 1'b0);
`endif

    // Mid-operation reset with words in both accumulator and output register
    fifo.delete();
    for (int i = 0; i < 6; i++) fifo.push_back(8'(8'h40 + i));
    for (int i = 0; i < 7; i++) step(0, 0, 0);
    apply_reset();
    for (int k = 0; k < 20 && fifo.size() != 0; k++) step(0, 1, 0);
    step(1, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0);

    // Randomized traffic, backpressure and flushes; scoreboard on byte order
    fifo.delete();
    sent.delete();
    log_d.delete(); log_c.delete();
    for (int i = 0; i < 600; i++) begin
      if (fifo.size() < 6 && ($urandom % 2) == 0) begin
        logic [7:0] b;
        b = 8'($urandom);
        fifo.push_back(b);
        sent.push_back(b);
      end
      step(($urandom % 4) == 0, ($urandom % 3) != 0, ($urandom % 16) == 0);
    end
    for (int k = 0; k < 200 && fifo.size() != 0; k++) step(0, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 0);
    recv.delete();
    foreach (log_d[j]) begin
      for (int l = 0; l < log_c[j]; l++) recv.push_back(log_d[j][l*8 +: 8]);
    end
    check("rand_byte_count", recv.size(), sent.size());
    for (int i = 0; i < sent.size() && i < recv.size(); i++) begin
      check("rand_byte", recv[i], sent[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
